// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage and its register file.
//   - Datapath width, register-file depth and index width
//   - FSM state codes (IDLE=00, RD_A=01, RD_B=10, VALID=11)
//   - Shift encodings applied to operand B
//   - ALU operation codes forwarded to the ALU
//   - Packed record of the per-fetch control fields captured on accept
package operand_fetch_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RD_A  = 2'b01,
        RD_B  = 2'b10,
        VALID = 2'b11
    } fetch_state_t;

    typedef enum logic [1:0] {
        SHIFT_NONE = 2'b00,
        SHIFT_LSL  = 2'b01,
        SHIFT_LSR  = 2'b10,
        SHIFT_ASR  = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_NOTB = 2'b11
    } aluop_t;

    // Control fields of one fetch request, captured when start is accepted.
    typedef struct packed {
        logic [IDX_W-1:0] rnum_a;
        logic [IDX_W-1:0] rnum_b;
        shift_t           shift;
        logic             asel;
        logic             bsel;
        aluop_t           aluop;
    } fetch_ctl_t;

endpackage

// File: rtl/regfile_8x16.sv
// Register file: NREGS x WIDTH, one write port and one combinational read port.
//   clk       in  rising-edge clock
//   reset     in  synchronous active-high clear of every register
//   write     in  write enable, honoured at the rising edge
//   writenum  in  write index
//   data_in   in  write data
//   readnum   in  read index
//   data_out  out read data; returns data_in when the same index is written
//                 in this cycle (write-through bypass)
module regfile_8x16
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int NREGS = NUM_REGS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [IDX_W-1:0] writenum,
    input  logic [WIDTH-1:0] data_in,
    input  logic [IDX_W-1:0] readnum,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] regs [NREGS];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            localparam logic [IDX_W-1:0] IDX = IDX_W'(gi);
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs[gi] <= '0;
                end else if (write && (writenum == IDX)) begin
                    regs[gi] <= data_in;
                end
            end
        end
    endgenerate

    // Bypass lets a fetch see a value being written in the same cycle.
    always_comb begin
        data_out = regs[readnum];
        if (write && (writenum == readnum)) begin
            data_out = data_in;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage in front of the 16-bit ALU.
// Sequences IDLE -> RD_A -> RD_B -> VALID: reads register A into Ain, then
// register B through the 1-bit shifter into Bin, and presents Ain/Bin/ALUop
// under a valid/ready handshake. Writeback enters via the register-file
// write port in every state.
//   clk, reset            clock and synchronous active-high reset
//   start / start_ready   fetch request handshake (ready only in IDLE)
//   readnum_a, readnum_b  register indices for Ain / Bin
//   shift                 B shift: pass, <<1, logical >>1, arithmetic >>1
//   asel, bsel            force Ain to 0 / select imm for Bin
//   imm                   immediate operand
//   aluop_in, ALUop       ALU operation, latched and passed through
//   write, writenum, data_in  register-file write port
//   Ain, Bin              registered ALU operands
//   out_valid / out_ready operand handshake with the ALU
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int NREGS = NUM_REGS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             start_ready,
    input  logic [IDX_W-1:0] readnum_a,
    input  logic [IDX_W-1:0] readnum_b,
    input  logic [1:0]       shift,
    input  logic             asel,
    input  logic             bsel,
    input  logic [WIDTH-1:0] imm,
    input  logic [1:0]       aluop_in,
    input  logic             write,
    input  logic [IDX_W-1:0] writenum,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] Ain,
    output logic [WIDTH-1:0] Bin,
    output logic [1:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready
);

    fetch_state_t     state_reg;
    fetch_state_t     state_next;
    fetch_ctl_t       ctl_reg;
    logic [WIDTH-1:0] imm_reg;
    logic [WIDTH-1:0] ain_reg;
    logic [WIDTH-1:0] bin_reg;
    logic [IDX_W-1:0] rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] shifted;

    // One read port serves both operands: A in RD_A, B in RD_B.
    assign rd_addr = (state_reg == RD_B) ? ctl_reg.rnum_b : ctl_reg.rnum_a;

    regfile_8x16 #(
        .WIDTH(WIDTH),
        .NREGS(NREGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .write   (write),
        .writenum(writenum),
        .data_in (data_in),
        .readnum (rd_addr),
        .data_out(rd_data)
    );

    always_comb begin
        shifted = rd_data;
        case (ctl_reg.shift)
            SHIFT_NONE: shifted = rd_data;
            SHIFT_LSL:  shifted = {rd_data[WIDTH-2:0], 1'b0};
            SHIFT_LSR:  shifted = {1'b0, rd_data[WIDTH-1:1]};
            SHIFT_ASR:  shifted = {rd_data[WIDTH-1], rd_data[WIDTH-1:1]};
            default:    shifted = rd_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        start_ready = 1'b0;
        out_valid   = 1'b0;
        case (state_reg)
            IDLE: begin
                start_ready = 1'b1;
                if (start) begin
                    state_next = RD_A;
                end
            end
            RD_A:  state_next = RD_B;
            RD_B:  state_next = VALID;
            VALID: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand and request registers; Ain/Bin only change in RD_A/RD_B, so
    // they stay stable through VALID and after the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_reg <= '0;
            imm_reg <= '0;
            ain_reg <= '0;
            bin_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        ctl_reg.rnum_a <= readnum_a;
                        ctl_reg.rnum_b <= readnum_b;
                        ctl_reg.shift  <= shift_t'(shift);
                        ctl_reg.asel   <= asel;
                        ctl_reg.bsel   <= bsel;
                        ctl_reg.aluop  <= aluop_t'(aluop_in);
                        imm_reg        <= imm;
                    end
                end
                RD_A: ain_reg <= ctl_reg.asel ? '0 : rd_data;
                RD_B: bin_reg <= ctl_reg.bsel ? imm_reg : shifted;
                default: ;
            endcase
        end
    end

    assign Ain   = ain_reg;
    assign Bin   = bin_reg;
    assign ALUop = ctl_reg.aluop;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        start_ready;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [15:0] imm;
    logic [1:0]  aluop_in;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic [15:0] Ain;
    logic [15:0] Bin;
    logic [1:0]  ALUop;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    operand_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_ready(start_ready),
        .readnum_a  (readnum_a),
        .readnum_b  (readnum_b),
        .shift      (shift),
        .asel       (asel),
        .bsel       (bsel),
        .imm        (imm),
        .aluop_in   (aluop_in),
        .write      (write),
        .writenum   (writenum),
        .data_in    (data_in),
        .Ain        (Ain),
        .Bin        (Bin),
        .ALUop      (ALUop),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [1:0]  sh;
        logic        as;
        logic        bs;
        logic [15:0] im;
        logic [1:0]  op;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
        write    = 1'b1;
        writenum = idx;
        data_in  = val;
        tick();
        write    = 1'b0;
    endtask

    // Presents a request and lets it be accepted at the next edge; afterwards
    // the DUT should be in RD_A.
    task automatic issue(input vec_t v);
        readnum_a = v.ra;
        readnum_b = v.rb;
        shift     = v.sh;
        asel      = v.as;
        bsel      = v.bs;
        imm       = v.im;
        aluop_in  = v.op;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        readnum_a = 3'd7;
        readnum_b = 3'd7;
        imm       = 16'hDEAD;
        shift     = 2'b00;
    endtask

    // Full fetch with exact latency checks and immediate handshake.
    task automatic run_vec(input string tag, input vec_t v);
        issue(v);
        check({tag, " valid@1"}, 32'(out_valid), 32'd0);
        check({tag, " ready@1"}, 32'(start_ready), 32'd0);
        tick();
        check({tag, " valid@2"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, " valid@3"}, 32'(out_valid), 32'd1);
        check({tag, " Ain"}, 32'(Ain), 32'(v.exp_a));
        check({tag, " Bin"}, 32'(Bin), 32'(v.exp_b));
        check({tag, " ALUop"}, 32'(ALUop), 32'(v.op));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " ready back"}, 32'(start_ready), 32'd1);
        check({tag, " Bin hold"}, 32'(Bin), 32'(v.exp_b));
        $display("txn %s: A=%0d B=%0d sh=%0d asel=%0d bsel=%0d -> Ain=%h Bin=%h ALUop=%0d",
                 tag, v.ra, v.rb, v.sh, v.as, v.bs, Ain, Bin, ALUop);
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; start = 1'b0; readnum_a = '0; readnum_b = '0; shift = '0;
        asel = 1'b0; bsel = 1'b0; imm = '0; aluop_in = '0; write = 1'b0;
        writenum = '0; data_in = '0; out_ready = 1'b0;

        //           ra    rb    sh     as    bs    imm       op     exp_a     exp_b
        vecs[0] = '{3'd3, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0007, 16'h0007};
        vecs[1] = '{3'd3, 3'd1, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b01, 16'h0007, 16'hE1E2};
        vecs[2] = '{3'd3, 3'd1, 2'b10, 1'b0, 1'b0, 16'h0000, 2'b10, 16'h0007, 16'h7878};
        vecs[3] = '{3'd3, 3'd1, 2'b11, 1'b0, 1'b0, 16'h0000, 2'b11, 16'h0007, 16'hF878};
        vecs[4] = '{3'd1, 3'd1, 2'b11, 1'b1, 1'b1, 16'h0015, 2'b00, 16'h0000, 16'h0015};
        vecs[5] = '{3'd1, 3'd4, 2'b11, 1'b0, 1'b0, 16'h0000, 2'b10, 16'hF0F1, 16'hC000};
        vecs[6] = '{3'd4, 3'd4, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b01, 16'h8001, 16'h0002};
        vecs[7] = '{3'd0, 3'd4, 2'b10, 1'b0, 1'b0, 16'h0000, 2'b11, 16'h0000, 16'h4000};

        tick();
        tick();
        reset = 1'b0;
        check("rst Ain", 32'(Ain), 32'd0);
        check("rst Bin", 32'(Bin), 32'd0);
        check("rst ALUop", 32'(ALUop), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst start_ready", 32'(start_ready), 32'd1);

        write_reg(3'd3, 16'h0007);
        write_reg(3'd1, 16'hF0F1);
        write_reg(3'd4, 16'h8001);

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Stall in VALID for 5 cycles; a second start must be ignored.
        v = '{3'd1, 3'd3, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b10, 16'hF0F1, 16'h000E};
        issue(v);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            start     = (c == 2);
            readnum_a = 3'd4;
            readnum_b = 3'd4;
            check($sformatf("stall%0d valid", c), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d ready", c), 32'(start_ready), 32'd0);
            check($sformatf("stall%0d Ain", c), 32'(Ain), 32'hF0F1);
            check($sformatf("stall%0d Bin", c), 32'(Bin), 32'h000E);
            check($sformatf("stall%0d ALUop", c), 32'(ALUop), 32'd2);
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall release valid", 32'(out_valid), 32'd0);
        check("stall release ready", 32'(start_ready), 32'd1);
        tick();
        check("stall no queued start", 32'(start_ready), 32'd1);
        $display("txn stall: Ain=%h Bin=%h after release", Ain, Bin);

        // Write-through bypass while B is being read.
        write_reg(3'd2, 16'h1111);
        v = '{3'd3, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0007, 16'hABCD};
        issue(v);
        tick();
        write    = 1'b1;
        writenum = 3'd2;
        data_in  = 16'hABCD;
        tick();
        write    = 1'b0;
        check("bypass valid", 32'(out_valid), 32'd1);
        check("bypass Bin", 32'(Bin), 32'hABCD);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("txn bypass: Bin=%h", Bin);
        v = '{3'd2, 3'd0, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 16'hABCD, 16'h0000};
        run_vec("bypass stored", v);

        // Reset while in RD_A discards the fetch and clears the registers.
        write_reg(3'd5, 16'h1234);
        v = '{3'd5, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b11, 16'h1234, 16'h1234};
        issue(v);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst valid", 32'(out_valid), 32'd0);
        check("midrst ready", 32'(start_ready), 32'd1);
        check("midrst Ain", 32'(Ain), 32'd0);
        check("midrst Bin", 32'(Bin), 32'd0);
        check("midrst ALUop", 32'(ALUop), 32'd0);
        $display("txn midreset: Ain=%h Bin=%h ALUop=%0d", Ain, Bin, ALUop);
        v = '{3'd5, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b01, 16'h0000, 16'h0000};
        run_vec("R5 cleared", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
